alu_control: RTL and testbench



---
 rtl/alu_ctrl_pkg.sv | 22 ++
 rtl/alu_ctrl_decode.sv | 45 ++++
 rtl/alu_control.sv | 39 +++
 tb/tb_alu_control.sv | 187 ++++++++++++++++++
 4 files changed

// File: rtl/alu_ctrl_pkg.sv
// Shared encodings for the ALU control decoder: ALU select codes, aluOp codes
// and R-type funct codes.
package alu_ctrl_pkg;

    localparam logic [2:0] ALU_AND = 3'b000;
    localparam logic [2:0] ALU_OR  = 3'b001;
    localparam logic [2:0] ALU_ADD = 3'b010;
    localparam logic [2:0] ALU_SUB = 3'b110;
    localparam logic [2:0] ALU_SLT = 3'b111;

    localparam logic [1:0] ALUOP_MEM   = 2'b00;
    localparam logic [1:0] ALUOP_BEQ   = 2'b01;
    localparam logic [1:0] ALUOP_RTYPE = 2'b10;
    localparam logic [1:0] ALUOP_RSVD  = 2'b11;

    localparam logic [5:0] FN_ADD = 6'b100000;
    localparam logic [5:0] FN_SUB = 6'b100010;
    localparam logic [5:0] FN_AND = 6'b100100;
    localparam logic [5:0] FN_OR  = 6'b100101;
    localparam logic [5:0] FN_SLT = 6'b101010;

endpackage

// File: rtl/alu_ctrl_decode.sv
// Combinational decode of aluOp/func into the next ALU select and error flag.
module alu_ctrl_decode
    import alu_ctrl_pkg::*;
(
    input  logic [1:0] aluOp,
    input  logic [5:0] func,
    output logic [2:0] next_ctr,
    output logic       next_err
);

    always_comb begin
        // Anything not explicitly decoded falls back to ADD with the error flag.
        next_ctr = ALU_ADD;
        next_err = 1'b1;
        case (aluOp)
            ALUOP_MEM: begin
                next_ctr = ALU_ADD;
                next_err = 1'b0;
            end
            ALUOP_BEQ: begin
                next_ctr = ALU_SUB;
                next_err = 1'b0;
            end
            ALUOP_RTYPE: begin
                next_err = 1'b0;
                case (func)
                    FN_ADD:  next_ctr = ALU_ADD;
                    FN_SUB:  next_ctr = ALU_SUB;
                    FN_AND:  next_ctr = ALU_AND;
                    FN_OR:   next_ctr = ALU_OR;
                    FN_SLT:  next_ctr = ALU_SLT;
                    default: begin
                        next_ctr = ALU_ADD;
                        next_err = 1'b1;
                    end
                endcase
            end
            default: begin
                next_ctr = ALU_ADD;
                next_err = 1'b1;
            end
        endcase
    end

endmodule

// File: rtl/alu_control.sv
// ALU control decoder with a single registered output stage; outputs come
// straight from flops so they never glitch between edges.
module alu_control
    import alu_ctrl_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic [5:0] func,
    input  logic [1:0] aluOp,
    output logic [2:0] aluCtr,
    output logic       aluCtr_err
);

    logic [2:0] w_next_ctr;
    logic       w_next_err;
    logic [2:0] r_ctr;
    logic       r_err;

    alu_ctrl_decode u_decode (
        .aluOp    (aluOp),
        .func     (func),
        .next_ctr (w_next_ctr),
        .next_err (w_next_err)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ctr <= ALU_ADD;
            r_err <= 1'b0;
        end else begin
            r_ctr <= w_next_ctr;
            r_err <= w_next_err;
        end
    end

    assign aluCtr     = r_ctr;
    assign aluCtr_err = r_err;

endmodule

// File: tb/tb_alu_control.sv
// Directed self-checking bench for alu_control.
module tb_alu_control;

    logic       clk;
    logic       rst_n;
    logic [5:0] func;
    logic [1:0] aluOp;
    logic [2:0] aluCtr;
    logic       aluCtr_err;

    int checks = 0;
    int errors = 0;

    alu_control dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .func       (func),
        .aluOp      (aluOp),
        .aluCtr     (aluCtr),
        .aluCtr_err (aluCtr_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Drive inputs, then land 1 time unit past the next rising edge.
    task automatic step(input logic [1:0] op, input logic [5:0] fn);
        aluOp = op;
        func  = fn;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        step(2'b10, 6'b100100);
        checks++;
        if ({aluCtr, aluCtr_err} !== 4'b0000) begin
            errors++;
            $display("FAIL pre_reset_and got=%b/%b exp=000/0", aluCtr, aluCtr_err);
        end
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if ({aluCtr, aluCtr_err} !== 4'b0100) begin
            errors++;
            $display("FAIL reset_immediate got=%b/%b exp=010/0", aluCtr, aluCtr_err);
        end
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if ({aluCtr, aluCtr_err} !== 4'b0100) begin
            errors++;
            $display("FAIL reset_hold got=%b/%b exp=010/0", aluCtr, aluCtr_err);
        end
        #3;
        rst_n = 1'b1;
        #1;
        checks++;
        if ({aluCtr, aluCtr_err} !== 4'b0100) begin
            errors++;
            $display("FAIL reset_release_no_edge got=%b/%b exp=010/0", aluCtr, aluCtr_err);
        end
        @(posedge clk);
        #1;
        checks++;
        if ({aluCtr, aluCtr_err} !== 4'b0000) begin
            errors++;
            $display("FAIL reset_first_edge got=%b/%b exp=000/0", aluCtr, aluCtr_err);
        end
    endtask

    task automatic test_rtype();
        logic [5:0] fns  [5] = '{6'b100000, 6'b100100, 6'b100101, 6'b100010, 6'b101010};
        logic [2:0] exps [5] = '{3'b010, 3'b000, 3'b001, 3'b110, 3'b111};
        for (int i = 0; i < 5; i++) begin
            step(2'b10, fns[i]);
            checks++;
            if ({aluCtr, aluCtr_err} !== {exps[i], 1'b0}) begin
                errors++;
                $display("FAIL rtype func=%b got=%b/%b exp=%b/0",
                         fns[i], aluCtr, aluCtr_err, exps[i]);
            end
        end
    endtask

    task automatic test_non_rtype();
        logic [1:0] ops  [3] = '{2'b00, 2'b01, 2'b01};
        logic [5:0] fns  [3] = '{6'b100010, 6'b100010, 6'b100100};
        logic [2:0] exps [3] = '{3'b010, 3'b110, 3'b110};
        for (int i = 0; i < 3; i++) begin
            step(ops[i], fns[i]);
            checks++;
            if ({aluCtr, aluCtr_err} !== {exps[i], 1'b0}) begin
                errors++;
                $display("FAIL non_rtype op=%b func=%b got=%b/%b exp=%b/0",
                         ops[i], fns[i], aluCtr, aluCtr_err, exps[i]);
            end
        end
    endtask

    task automatic test_illegal();
        logic [1:0] ops [4] = '{2'b10, 2'b11, 2'b11, 2'b11};
        logic [5:0] fns [4] = '{6'b000000, 6'b100000, 6'b101010, 6'b111111};
        for (int i = 0; i < 4; i++) begin
            step(ops[i], fns[i]);
            checks++;
            if ({aluCtr, aluCtr_err} !== 4'b0101) begin
                errors++;
                $display("FAIL illegal op=%b func=%b got=%b/%b exp=010/1",
                         ops[i], fns[i], aluCtr, aluCtr_err);
            end
        end
        step(2'b10, 6'b100101);
        checks++;
        if ({aluCtr, aluCtr_err} !== 4'b0010) begin
            errors++;
            $display("FAIL err_clear got=%b/%b exp=001/0", aluCtr, aluCtr_err);
        end
    endtask

    task automatic test_latency();
        step(2'b10, 6'b100100);
        aluOp = 2'b01;
        func  = 6'b000000;
        #3;
        checks++;
        if ({aluCtr, aluCtr_err} !== 4'b0000) begin
            errors++;
            $display("FAIL latency_hold got=%b/%b exp=000/0", aluCtr, aluCtr_err);
        end
        @(posedge clk);
        #1;
        checks++;
        if ({aluCtr, aluCtr_err} !== 4'b1100) begin
            errors++;
            $display("FAIL latency_update got=%b/%b exp=110/0", aluCtr, aluCtr_err);
        end
    endtask

    task automatic test_async_reset_midstream();
        step(2'b10, 6'b101010);
        checks++;
        if ({aluCtr, aluCtr_err} !== 4'b1110) begin
            errors++;
            $display("FAIL midstream_pre got=%b/%b exp=111/0", aluCtr, aluCtr_err);
        end
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if ({aluCtr, aluCtr_err} !== 4'b0100) begin
            errors++;
            $display("FAIL midstream_reset got=%b/%b exp=010/0", aluCtr, aluCtr_err);
        end
        @(posedge clk);
        #1;
        checks++;
        if ({aluCtr, aluCtr_err} !== 4'b0100) begin
            errors++;
            $display("FAIL midstream_reset_hold got=%b/%b exp=010/0", aluCtr, aluCtr_err);
        end
        #3;
        rst_n = 1'b1;
        step(2'b10, 6'b100101);
        checks++;
        if ({aluCtr, aluCtr_err} !== 4'b0010) begin
            errors++;
            $display("FAIL post_reset_or got=%b/%b exp=001/0", aluCtr, aluCtr_err);
        end
    endtask

    initial begin
        rst_n = 1'b1;
        aluOp = 2'b10;
        func  = 6'b100100;
        test_reset();
        test_rtype();
        test_non_rtype();
        test_illegal();
        test_latency();
        test_async_reset_midstream();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
